// File: rtl/cordic_job_scheduler.sv
// Round-robin scheduler sharing one CORDIC accelerator: grant -> 1-cycle launch -> busy until Ready -> response.
// One job in flight; req_ready only in IDLE, response held until rsp_ready, watchdog forces one stop pulse.
module cordic_job_scheduler #(
    parameter int p_WIDTH    = 32,
    parameter int p_NUM_REQ  = 4,
    parameter int p_ID_WIDTH = 2,
    parameter int p_TIMEOUT  = 63
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [p_NUM_REQ-1:0]           req_valid,
    output logic [p_NUM_REQ-1:0]           req_ready,
    input  logic [p_NUM_REQ*16-1:0]        req_ctrl,
    input  logic [p_NUM_REQ*p_WIDTH-1:0]   req_x,
    input  logic [p_NUM_REQ*p_WIDTH-1:0]   req_y,
    input  logic [p_NUM_REQ*p_WIDTH-1:0]   req_z,
    output logic [31:0]                    acc_ctrl_in,
    output logic [p_WIDTH-1:0]             acc_x_in,
    output logic [p_WIDTH-1:0]             acc_y_in,
    output logic [p_WIDTH-1:0]             acc_z_in,
    input  logic [31:0]                    acc_ctrl_out,
    input  logic                           acc_ctrl_we,
    input  logic [p_WIDTH-1:0]             acc_x_res,
    input  logic [p_WIDTH-1:0]             acc_y_res,
    input  logic [p_WIDTH-1:0]             acc_z_res,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [p_ID_WIDTH-1:0]          rsp_id,
    output logic [p_WIDTH-1:0]             rsp_x,
    output logic [p_WIDTH-1:0]             rsp_y,
    output logic [p_WIDTH-1:0]             rsp_z,
    output logic [3:0]                     rsp_flags,
    output logic [4:0]                     rsp_iter,
    output logic                           busy
);

    localparam int                    lp_SW   = p_ID_WIDTH + 1;
    localparam logic [lp_SW-1:0]      lp_NREQ = lp_SW'(p_NUM_REQ);
    localparam logic [p_ID_WIDTH-1:0] lp_LAST = p_ID_WIDTH'(p_NUM_REQ - 1);
    localparam logic [7:0]            lp_TO   = 8'(p_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [p_ID_WIDTH-1:0]   r_rr_ptr;
    logic [p_ID_WIDTH-1:0]   r_id;
    logic [15:0]             r_ctrl;
    logic [p_WIDTH-1:0]      r_x;
    logic [p_WIDTH-1:0]      r_y;
    logic [p_WIDTH-1:0]      r_z;
    logic [7:0]              r_wdog;
    logic                    r_stop_sent;
    logic                    r_rsp_vld;
    logic [p_ID_WIDTH-1:0]   r_rsp_id;
    logic [p_WIDTH-1:0]      r_rsp_x;
    logic [p_WIDTH-1:0]      r_rsp_y;
    logic [p_WIDTH-1:0]      r_rsp_z;
    logic [3:0]              r_rsp_flags;
    logic [4:0]              r_rsp_iter;

    logic                    w_gnt_vld;
    logic [p_ID_WIDTH-1:0]   w_gnt_id;
    logic [lp_SW-1:0]        w_sum;
    logic                    w_done;
    logic                    w_stop;
    logic                    w_unused_ok;

    // First valid requester at or after r_rr_ptr, scanning upward with wrap.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_sum     = '0;
        for (int i = 0; i < p_NUM_REQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + lp_SW'(i);
            if (w_sum >= lp_NREQ) begin
                w_sum = w_sum - lp_NREQ;
            end
            if (!w_gnt_vld && req_valid[w_sum[p_ID_WIDTH-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_sum[p_ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        acc_ctrl_in = '0;
        w_done      = 1'b0;
        w_stop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_vld && !rst) begin
                    req_ready[w_gnt_id] = 1'b1;
                end
                if (w_gnt_vld) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                acc_ctrl_in = {16'b0, r_ctrl[15:2], 1'b0, 1'b1};
                w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                // The acceptance write-enable carries Ready=0; only Ready=1 ends the job.
                w_done      = acc_ctrl_we && acc_ctrl_out[16];
                w_stop      = !w_done && !r_stop_sent && (r_wdog == lp_TO);
                acc_ctrl_in = {16'b0, r_ctrl[15:2], w_stop, 1'b0};
                if (w_done) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_ctrl      <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_wdog      <= '0;
            r_stop_sent <= 1'b0;
            r_rsp_vld   <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_x     <= '0;
            r_rsp_y     <= '0;
            r_rsp_z     <= '0;
            r_rsp_flags <= '0;
            r_rsp_iter  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_id   <= w_gnt_id;
                        r_ctrl <= req_ctrl[int'(w_gnt_id)*16 +: 16];
                        r_x    <= req_x[int'(w_gnt_id)*p_WIDTH +: p_WIDTH];
                        r_y    <= req_y[int'(w_gnt_id)*p_WIDTH +: p_WIDTH];
                        r_z    <= req_z[int'(w_gnt_id)*p_WIDTH +: p_WIDTH];
                    end
                end
                S_LAUNCH: begin
                    r_wdog <= '0;
                end
                S_BUSY: begin
                    if (r_wdog != 8'hFF) begin
                        r_wdog <= r_wdog + 8'd1;
                    end
                    if (w_stop) begin
                        r_stop_sent <= 1'b1;
                    end
                    if (w_done) begin
                        r_rsp_vld   <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_x     <= acc_x_res;
                        r_rsp_y     <= acc_y_res;
                        r_rsp_z     <= acc_z_res;
                        r_rsp_flags <= {r_stop_sent, acc_ctrl_out[21], acc_ctrl_out[18], acc_ctrl_out[17]};
                        r_rsp_iter  <= acc_ctrl_out[26:22];
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_vld   <= 1'b0;
                        r_stop_sent <= 1'b0;
                        r_rr_ptr    <= (r_id == lp_LAST) ? '0 : r_id + p_ID_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign acc_x_in  = r_x;
    assign acc_y_in  = r_y;
    assign acc_z_in  = r_z;
    assign rsp_valid = r_rsp_vld;
    assign rsp_id    = r_rsp_id;
    assign rsp_x     = r_rsp_x;
    assign rsp_y     = r_rsp_y;
    assign rsp_z     = r_rsp_z;
    assign rsp_flags = r_rsp_flags;
    assign rsp_iter  = r_rsp_iter;
    assign busy      = (r_state != S_IDLE);

    assign w_unused_ok = ^{acc_ctrl_out[31:27], acc_ctrl_out[20:19], acc_ctrl_out[15:0], r_ctrl[1:0]};

endmodule

// File: tb/tb_cordic_job_scheduler.sv
// Directed bench for cordic_job_scheduler: main instance with default timeout, second instance with timeout 8.
module tb_cordic_job_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [63:0]  req_ctrl;
    logic [127:0] req_x, req_y, req_z;
    logic         rsp_ready;
    logic [31:0]  acc_x_res, acc_y_res, acc_z_res;

    logic [3:0]   req_ready;
    logic [31:0]  acc_ctrl_in, acc_x_in, acc_y_in, acc_z_in;
    logic [31:0]  acc_ctrl_out;
    logic         acc_ctrl_we;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_x, rsp_y, rsp_z;
    logic [3:0]   rsp_flags;
    logic [4:0]   rsp_iter;
    logic         busy;

    logic [3:0]   w2_req_ready;
    logic [31:0]  w2_ctrl_in, w2_x_in, w2_y_in, w2_z_in;
    logic [31:0]  w2_ctrl_out;
    logic         w2_we;
    logic         w2_rsp_valid;
    logic [1:0]   w2_rsp_id;
    logic [31:0]  w2_rsp_x, w2_rsp_y, w2_rsp_z;
    logic [3:0]   w2_rsp_flags;
    logic [4:0]   w2_rsp_iter;
    logic         w2_busy;

    int total = 0;
    int bad   = 0;
    int starts;
    int stops;

    logic [3:0] exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    always #5 clk = ~clk;

    cordic_job_scheduler #(.p_WIDTH(32), .p_NUM_REQ(4), .p_ID_WIDTH(2), .p_TIMEOUT(63)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .acc_ctrl_in(acc_ctrl_in), .acc_x_in(acc_x_in), .acc_y_in(acc_y_in), .acc_z_in(acc_z_in),
        .acc_ctrl_out(acc_ctrl_out), .acc_ctrl_we(acc_ctrl_we),
        .acc_x_res(acc_x_res), .acc_y_res(acc_y_res), .acc_z_res(acc_z_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
        .rsp_flags(rsp_flags), .rsp_iter(rsp_iter), .busy(busy)
    );

    cordic_job_scheduler #(.p_WIDTH(32), .p_NUM_REQ(4), .p_ID_WIDTH(2), .p_TIMEOUT(8)) dut_wd (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(w2_req_ready), .req_ctrl(req_ctrl),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .acc_ctrl_in(w2_ctrl_in), .acc_x_in(w2_x_in), .acc_y_in(w2_y_in), .acc_z_in(w2_z_in),
        .acc_ctrl_out(w2_ctrl_out), .acc_ctrl_we(w2_we),
        .acc_x_res(acc_x_res), .acc_y_res(acc_y_res), .acc_z_res(acc_z_res),
        .rsp_valid(w2_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(w2_rsp_id),
        .rsp_x(w2_rsp_x), .rsp_y(w2_rsp_y), .rsp_z(w2_rsp_z),
        .rsp_flags(w2_rsp_flags), .rsp_iter(w2_rsp_iter), .busy(w2_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive a Ready=1 completion into the main instance for one edge.
    task automatic complete_main(input logic [31:0] ctrl_out);
        acc_ctrl_we  = 1'b1;
        acc_ctrl_out = ctrl_out;
        tick;
        acc_ctrl_we  = 1'b0;
        acc_ctrl_out = '0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_ctrl = '0; req_x = '0; req_y = '0; req_z = '0;
        rsp_ready = 1'b0; acc_x_res = '0; acc_y_res = '0; acc_z_res = '0;
        acc_ctrl_out = '0; acc_ctrl_we = 1'b0; w2_ctrl_out = '0; w2_we = 1'b0;
        tick; tick;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ctrl_in", acc_ctrl_in, 0);
        chk("rst_req_ready", req_ready, 0);
        rst = 1'b0;
        tick;

        // Single job from requester 2, completion 18 cycles after start
        req_ctrl[2*16 +: 16] = 16'h003C;
        req_x[2*32 +: 32] = 32'h4000_0000;
        req_y[2*32 +: 32] = 32'h0000_0000;
        req_z[2*32 +: 32] = 32'h2000_0000;
        req_valid = 4'b0100;
        #1;
        chk("t1_grant", req_ready, 4'b0100);
        tick;
        req_valid = '0;
        chk("t1_launch_ctrl", acc_ctrl_in, 32'h0000_003D);
        chk("t1_launch_x", acc_x_in, 32'h4000_0000);
        chk("t1_launch_z", acc_z_in, 32'h2000_0000);
        chk("t1_busy", busy, 1);
        starts = 0;
        for (int c = 0; c < 18; c++) begin
            if (acc_ctrl_in[0]) starts++;
            tick;
        end
        chk("t1_no_early_rsp", rsp_valid, 0);
        chk("t1_x_held", acc_x_in, 32'h4000_0000);
        acc_x_res = 32'h1234_5678; acc_y_res = 32'h0000_0ABC; acc_z_res = 32'hFFFF_FFF0;
        complete_main(32'h03C1_0000);
        acc_x_res = '0; acc_y_res = '0; acc_z_res = '0;
        chk("t1_start_pulses", starts, 1);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 2);
        chk("t1_rsp_iter", rsp_iter, 15);
        chk("t1_rsp_flags", rsp_flags, 0);
        chk("t1_rsp_x", rsp_x, 32'h1234_5678);
        chk("t1_rsp_z", rsp_z, 32'hFFFF_FFF0);
        repeat (3) tick;
        chk("t1_rsp_hold_valid", rsp_valid, 1);
        chk("t1_rsp_hold_y", rsp_y, 32'h0000_0ABC);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk("t1_rsp_drop", rsp_valid, 0);
        chk("t1_idle", busy, 0);
        chk("t1_rsp_x_kept", rsp_x, 32'h1234_5678);

        // Round-robin with all four requesters valid
        rst = 1'b1;
        tick;
        rst = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("t2_grant", req_ready, exp_rdy[j]);
            tick;
            chk("t2_no_grant_launch", req_ready, 0);
            tick;
            acc_ctrl_we = 1'b1; acc_ctrl_out = 32'h0001_0000;
            #1;
            chk("t2_no_grant_busy", req_ready, 0);
            tick;
            acc_ctrl_we = 1'b0; acc_ctrl_out = '0;
            chk("t2_rsp_id", rsp_id, exp_id[j]);
            chk("t2_no_grant_resp", req_ready, 0);
            tick;
        end
        req_valid = '0;
        rsp_ready = 1'b0;

        // Acceptance write-enable with Ready=0 must not end the job
        req_valid = 4'b0010;
        #1;
        chk("t3_grant", req_ready, 4'b0010);
        tick;
        req_valid = '0;
        tick;
        acc_ctrl_we = 1'b1; acc_ctrl_out = 32'h0040_0000; acc_x_res = 32'hDEAD_BEEF;
        tick;
        acc_ctrl_we = 1'b0; acc_ctrl_out = '0;
        chk("t3_ignore_accept_busy", busy, 1);
        chk("t3_ignore_accept_rsp", rsp_valid, 0);
        repeat (8) tick;
        chk("t3_still_busy", rsp_valid, 0);
        acc_x_res = 32'h1111_2222;
        complete_main(32'h0241_0000);
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_rsp_x", rsp_x, 32'h1111_2222);
        chk("t3_rsp_iter", rsp_iter, 9);
        chk("t3_rsp_id", rsp_id, 1);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;

        // Error flags pass through from requester 3
        req_valid = 4'b1000;
        #1;
        chk("t5_grant", req_ready, 4'b1000);
        tick;
        req_valid = '0;
        tick;
        complete_main(32'h0007_0000);
        chk("t5_flags", rsp_flags, 4'b0011);
        chk("t5_rsp_id", rsp_id, 3);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;

        // Reset mid-BUSY and in RESP; pointer returns to 0
        req_valid = 4'b0010;
        tick;
        req_valid = '0;
        tick;
        complete_main(32'h0001_0000);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("t6_rr_from_2", req_ready, 4'b0100);
        tick;
        req_valid = '0;
        tick; tick;
        chk("t6_busy_before_rst", busy, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t6_busy_rst", busy, 0);
        chk("t6_ctrl_rst", acc_ctrl_in, 0);
        chk("t6_xin_rst", acc_x_in, 0);
        chk("t6_rspx_rst", rsp_x, 0);
        chk("t6_ready_rst", req_ready, 0);
        req_valid = 4'b1111;
        #1;
        chk("t6_rr_reset", req_ready, 4'b0001);
        tick;
        req_valid = '0;
        tick;
        complete_main(32'h0007_0000);
        chk("t6_resp_valid", rsp_valid, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t6_resp_rst_valid", rsp_valid, 0);
        chk("t6_resp_rst_busy", busy, 0);
        chk("t6_resp_rst_flags", rsp_flags, 0);
        chk("t6_resp_rst_ctrl", acc_ctrl_in, 0);

        // Watchdog on the timeout-8 instance
        rst = 1'b1;
        tick;
        rst = 1'b0;
        req_valid = 4'b0001;
        tick;
        req_valid = '0;
        tick;
        stops = 0;
        for (int c = 0; c < 8; c++) begin
            if (w2_ctrl_in[1]) stops++;
            tick;
        end
        chk("t4_stop_at_8", w2_ctrl_in[1], 1);
        if (w2_ctrl_in[1]) stops++;
        tick;
        chk("t4_stop_once", w2_ctrl_in[1], 0);
        if (w2_ctrl_in[1]) stops++;
        tick;
        w2_we = 1'b1; w2_ctrl_out = 32'h0001_0000;
        #1;
        if (w2_ctrl_in[1]) stops++;
        tick;
        w2_we = 1'b0; w2_ctrl_out = '0;
        chk("t4_stop_count", stops, 1);
        chk("t4_rsp_valid", w2_rsp_valid, 1);
        chk("t4_flags", w2_rsp_flags, 4'b1000);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;

        // Completion in the timeout cycle wins over the stop
        req_valid = 4'b0010;
        #1;
        chk("t4b_grant", w2_req_ready, 4'b0010);
        tick;
        req_valid = '0;
        tick;
        repeat (8) tick;
        w2_we = 1'b1; w2_ctrl_out = 32'h0001_0000;
        #1;
        chk("t4b_no_stop", w2_ctrl_in[1], 0);
        tick;
        w2_we = 1'b0; w2_ctrl_out = '0;
        chk("t4b_rsp_valid", w2_rsp_valid, 1);
        chk("t4b_flags", w2_rsp_flags, 4'b0000);
        chk("t4b_rsp_id", w2_rsp_id, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_job_scheduler.md
Name: cordic_job_scheduler

Overview:
- Shares one CORDIC accelerator between p_NUM_REQ requesters using round-robin arbitration.
- Sits between requester ports and the accelerator's bus-side register interface (control word, x/y/z inputs, results, control-register write-enable).
- Per granted job it latches operands, issues a one-cycle start, watches for completion, and returns results, flags and requester ID.
- A watchdog forces a stop on jobs that exceed the cycle limit.

Parameters:
- p_WIDTH, 32: operand/result width.
- p_NUM_REQ, 4: number of requesters (2..8).
- p_ID_WIDTH, 2: requester ID width; must equal clog2(p_NUM_REQ).
- p_TIMEOUT, 63: BUSY cycles before the stop bit is forced (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  p_NUM_REQ  per-requester job valid
- req_ready  out  p_NUM_REQ  one-hot accept
- req_ctrl  in  p_NUM_REQ*16  per-requester control bits [15:0]
- req_x / req_y / req_z  in  p_NUM_REQ*p_WIDTH each  per-requester operands; requester i uses slice i
- acc_ctrl_in  out  32  control word to accelerator
- acc_x_in / acc_y_in / acc_z_in  out  p_WIDTH each  operands to accelerator
- acc_ctrl_out  in  32  accelerator control register
- acc_ctrl_we  in  1  accelerator control-register write-enable
- acc_x_res / acc_y_res / acc_z_res  in  p_WIDTH each  accelerator results
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  p_ID_WIDTH  requester that owns the response
- rsp_x / rsp_y / rsp_z  out  p_WIDTH each  captured results
- rsp_flags  out  4  {timeout, z_ovf(bit21), ovf_err(bit18), inp_err(bit17)}
- rsp_iter  out  5  elapsed iterations, acc_ctrl_out[26:22]
- busy  out  1  high in any state except IDLE

Behaviour:
- All state updates on posedge clk.
- rst overrides everything in the same edge, including mid-job:
  - state goes to IDLE, rr_ptr=0, watchdog=0, stop_sent=0.
  - All outputs go to 0: req_ready, acc_*_in, rsp_*, busy.
- States:
  - IDLE: when any req_valid is high, req_ready is asserted combinationally for exactly one requester. That requester is the first valid one at or after rr_ptr, scanning upward with wrap. On the handshake, latch ID, req_ctrl, x, y and z, then go to LAUNCH. If no request is valid, stay in IDLE.
  - LAUNCH (1 cycle): acc_ctrl_in = {16'b0, latched_ctrl[15:2], 1'b0, 1'b1}; start=1, stop=0. acc_x/y/z_in = latched operands. Clear watchdog; go to BUSY.
  - BUSY:
    - acc_ctrl_in start=0; stop is asserted only in the forced-stop cycle (see watchdog below).
    - Operands stay held.
    - Watchdog increments every cycle.
    - Completion is acc_ctrl_we=1 and acc_ctrl_out[16]=1. The accelerator's write-enable pulse on job acceptance has Ready=0 and must be ignored.
    - On completion: capture acc_*_res, flags and iteration count into rsp_*; set flags[3]=stop_sent; go to RESP.
  - Watchdog: when the counter reaches p_TIMEOUT and stop_sent=0, drive acc_ctrl_in[1]=1 for exactly one cycle, set stop_sent=1, and keep waiting for completion. Completion and timeout in the same cycle: completion wins, no stop is issued, and flags[3]=0.
  - RESP: hold rsp_valid=1 and all rsp_* stable until rsp_ready=1. On that handshake: rsp_valid goes to 0 next cycle; rr_ptr = granted ID + 1, wrapping modulo p_NUM_REQ; clear stop_sent; go to IDLE.
- req_ready is 0 outside IDLE. A new job cannot be granted in the same cycle as the response handshake. Minimum job-to-job gap is one IDLE cycle.
- rsp_* outputs keep their last values after the handshake; only rsp_valid drops.
- Only one job is ever in flight.

Test Plan:
- Single job, circular rotation: requester 2 sends x=0x4000_0000, y=0, z=0x2000_0000, ctrl iter=15, model completes after 18 cycles -> exactly one start pulse; rsp_id=2; rsp_iter=15; rsp_flags=0; rsp_valid held until rsp_ready.
- Round-robin fairness: all four requesters valid continuously, rsp_ready tied 1 -> grant order 0,1,2,3,0; req_ready one-hot; never two grants without an intervening response.
- Ignored acceptance write-enable: model asserts acc_ctrl_we with Ready=0 one cycle after start, then Ready=1 at cycle 10 -> scheduler stays in BUSY until cycle 10; results captured from cycle 10 only.
- Watchdog: p_TIMEOUT=8, model never completes until it sees stop, then finishes 2 cycles later -> stop bit high for exactly 1 cycle at BUSY cycle 8; rsp_flags[3]=1.
- Error passthrough: model returns acc_ctrl_out bits 17 and 18 set -> rsp_flags=4'b0011 with the correct rsp_id.
- Reset mid-BUSY and in RESP with rsp_ready=0 -> next cycle all outputs 0, busy=0, state IDLE; a following request from requester 0 is granted first (rr_ptr=0).
